// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data SRAM port arbiter: fixed CPU priority, bounded DMA starvation
// CPU wins by default; an eligible DMA request wins after STARVE_LIMIT consecutive losses.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [7:0]  cpu_wea,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_din,
    output logic [63:0] cpu_dout,
    output logic        cpu_ready,
    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic [7:0]  dma_req_we,
    input  logic [63:0] dma_req_addr,
    input  logic [63:0] dma_req_wdata,
    output logic        dma_rsp_valid,
    input  logic        dma_rsp_ready,
    output logic [63:0] dma_rsp_rdata,
    output logic [63:0] data_addra,
    output logic [63:0] data_dina,
    output logic        data_ena,
    output logic [7:0]  data_wea,
    input  logic [63:0] data_douta
);
    localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic          inflight_q, inflight_d;
    logic          inflight_rd_q, inflight_rd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [63:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          dma_elig;
    logic          dma_grant;

    // The slot may be refilled in the same cycle it drains, so a draining slot counts as free.
    always_comb begin
        dma_elig      = dma_req_valid & ~inflight_q & (~rsp_valid_q | dma_rsp_ready);
        dma_grant     = rst & dma_elig & (~cpu_en | (wait_cnt_q == LIMIT));
        cpu_ready     = rst & ~dma_grant;
        dma_req_ready = dma_grant;
        cpu_dout      = data_douta;
        dma_rsp_valid = rst & rsp_valid_q;
        dma_rsp_rdata = rsp_rdata_q;
        if (dma_grant) begin
            data_addra = dma_req_addr;
            data_dina  = dma_req_wdata;
            data_wea   = dma_req_we;
            data_ena   = 1'b1;
        end else begin
            data_addra = cpu_addr;
            data_dina  = cpu_din;
            data_wea   = rst ? cpu_wea : 8'h00;
            data_ena   = rst & cpu_en;
        end
    end

    always_comb begin
        inflight_d    = dma_grant;
        inflight_rd_d = inflight_rd_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        wait_cnt_d    = wait_cnt_q;
        if (dma_grant) begin
            inflight_rd_d = (dma_req_we == 8'h00);
        end
        if (inflight_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = inflight_rd_q ? data_douta : 64'h0;
        end else if (dma_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (dma_grant || !dma_req_valid) begin
            wait_cnt_d = '0;
        end else if (dma_elig && cpu_en && (wait_cnt_q != LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q    <= 1'b0;
            inflight_rd_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 64'h0;
            wait_cnt_q    <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_rd_q <= inflight_rd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [7:0]  cpu_wea;
    logic [63:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_ready;
    logic        dma_req_valid, dma_req_ready;
    logic [7:0]  dma_req_we;
    logic [63:0] dma_req_addr, dma_req_wdata;
    logic        dma_rsp_valid, dma_rsp_ready;
    logic [63:0] dma_rsp_rdata;
    logic [63:0] data_addra, data_dina, data_douta;
    logic        data_ena;
    logic [7:0]  data_wea;
    logic        sram_clr;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wea(cpu_wea), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_ready(dma_rsp_ready), .dma_rsp_rdata(dma_rsp_rdata),
        .data_addra(data_addra), .data_dina(data_dina), .data_ena(data_ena), .data_wea(data_wea),
        .data_douta(data_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: 16 words at 0x40..0xB8, one-cycle read latency
    logic [63:0] sram [16];
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 16; i++) sram[i] <= 64'h0;
            data_douta <= 64'h0;
        end else if (data_ena) begin
            data_douta <= sram[data_addra[6:3]];
            for (int b = 0; b < 8; b++)
                if (data_wea[b]) sram[data_addra[6:3]][8*b +: 8] <= data_dina[8*b +: 8];
        end
    end

    typedef struct packed {
        logic        cr, dr, ena, rv;
        logic [7:0]  wea;
        logic [63:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_cpu[$];
    logic [63:0] exp_dma[$];
    int          grant_cyc[$];
    logic [63:0] ref_mem [16];
    bit          m_infl, m_slot, cpu_hold, dma_hold, cpu_chk;
    int          m_wait, cyc, s0, nchk, nfail;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] we);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [7:0] rand_we();
        case ($urandom_range(3))
            1:       return 8'hFF;
            2:       return 8'($urandom());
            default: return 8'h00;
        endcase
    endfunction

    // Reference: predict this cycle's winner from the arbitration rules, log expectations,
    // then advance the abstract state (busy, slot, loss count, memory) across the edge.
    task automatic step();
        bit   elig, gd, gc;
        exp_t e;
        cyc++;
        elig = dma_req_valid && !m_infl && (!m_slot || dma_rsp_ready);
        gd   = rst && elig && (!cpu_en || m_wait == LIMIT);
        gc   = rst && !gd;
        e.cr   = gc;
        e.dr   = gd;
        e.ena  = rst && (gd || cpu_en);
        e.rv   = rst && m_slot;
        e.wea  = !rst ? 8'h00 : (gd ? dma_req_we : cpu_wea);
        e.addr = gd ? dma_req_addr : cpu_addr;
        exp_q.push_back(e);
        if (gd) begin
            exp_dma.push_back(dma_req_we == 8'h00 ? ref_mem[dma_req_addr[6:3]] : 64'h0);
            ref_mem[dma_req_addr[6:3]] = merge(ref_mem[dma_req_addr[6:3]], dma_req_wdata, dma_req_we);
        end else if (rst && cpu_en) begin
            if (cpu_wea == 8'h00) exp_cpu.push_back(ref_mem[cpu_addr[6:3]]);
            ref_mem[cpu_addr[6:3]] = merge(ref_mem[cpu_addr[6:3]], cpu_din, cpu_wea);
        end
        cpu_hold = cpu_en && !gc;
        dma_hold = dma_req_valid && !gd;
        @(posedge clk);
        if (!rst) begin
            m_infl = 0;
            m_slot = 0;
            m_wait = 0;
            exp_dma.delete();
        end else begin
            if (m_infl) m_slot = 1;
            else if (dma_rsp_ready) m_slot = 0;
            if (gd || !dma_req_valid) m_wait = 0;
            else if (elig && cpu_en) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
            m_infl = gd;
        end
        #1;
    endtask

    task automatic gen(input int cp, input int dp, input int rp);
        if (!cpu_hold) begin
            cpu_en   = int'($urandom_range(99)) < cp;
            cpu_addr = 64'h40 + 64'($urandom_range(15)) * 8;
            cpu_wea  = rand_we();
            cpu_din  = {$urandom(), $urandom()};
        end
        if (!dma_hold) begin
            dma_req_valid = int'($urandom_range(99)) < dp;
            dma_req_addr  = 64'h40 + 64'($urandom_range(15)) * 8;
            dma_req_we    = rand_we();
            dma_req_wdata = {$urandom(), $urandom()};
        end
        dma_rsp_ready = int'($urandom_range(99)) < rp;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_chk) begin
            chk("cpu_read_expected", 80'(exp_cpu.size() != 0), 80'd1);
            if (exp_cpu.size() != 0) chk("cpu_dout", 80'(cpu_dout), 80'(exp_cpu.pop_front()));
        end
        cpu_chk = cpu_en && cpu_ready && (cpu_wea == 8'h00);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("handshake{cpu_ready,dma_req_ready,data_ena,dma_rsp_valid}",
                80'({cpu_ready, dma_req_ready, data_ena, dma_rsp_valid}),
                80'({e.cr, e.dr, e.ena, e.rv}));
            chk("data_wea", 80'(data_wea), 80'(e.wea));
            chk("data_addra", 80'(data_addra), 80'(e.addr));
        end
        if (dma_rsp_valid) begin
            chk("dma_rsp_expected", 80'(exp_dma.size() != 0), 80'd1);
            if (exp_dma.size() != 0) begin
                chk("dma_rsp_rdata", 80'(dma_rsp_rdata), 80'(exp_dma[0]));
                if (dma_rsp_ready) void'(exp_dma.pop_front());
            end
        end
        if (dma_req_ready) grant_cyc.push_back(cyc);
    end

    initial begin
        nchk = 0; nfail = 0; cyc = 0; m_infl = 0; m_slot = 0; m_wait = 0;
        cpu_hold = 0; dma_hold = 0; cpu_chk = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 64'h0;
        sram_clr = 1'b1; rst = 1'b0;
        cpu_en = 1'b1; cpu_wea = 8'h00; cpu_addr = 64'h40; cpu_din = 64'h0;
        dma_req_valid = 1'b1; dma_req_we = 8'h00; dma_req_addr = 64'h48; dma_req_wdata = 64'h0;
        dma_rsp_ready = 1'b0;
        @(posedge clk); #1;
        sram_clr = 1'b0;
        repeat (3) step();

        // release reset into a CPU write, then read it back
        rst = 1'b1; dma_req_valid = 1'b0;
        cpu_wea = 8'hFF; cpu_addr = 64'h40; cpu_din = 64'h1122334455667788;
        step();
        cpu_wea = 8'h00; step();
        cpu_en = 1'b0; step();

        // DMA read with CPU idle; response holds while not consumed
        dma_req_valid = 1'b1; dma_req_we = 8'h00; dma_req_addr = 64'h40;
        step();
        dma_req_valid = 1'b0;
        repeat (4) step();
        chk("dma_rsp_rdata_directed", 80'(dma_rsp_rdata), 80'h1122334455667788);

        // backpressure: full slot blocks a second request until the slot drains
        dma_req_valid = 1'b1; dma_req_we = 8'hFF; dma_req_addr = 64'h48;
        dma_req_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        repeat (4) step();
        dma_rsp_ready = 1'b1; step();
        dma_req_valid = 1'b0; dma_rsp_ready = 1'b0;
        repeat (3) step();
        dma_rsp_ready = 1'b1; step();

        // reset in the cycle after a DMA grant drops the response
        dma_req_valid = 1'b1; dma_req_we = 8'h00; dma_req_addr = 64'h48;
        step();
        dma_req_valid = 1'b0; rst = 1'b0;
        repeat (2) step();
        rst = 1'b1; cpu_en = 1'b1; cpu_wea = 8'h00; cpu_addr = 64'h48;
        step();
        cpu_en = 1'b0;
        repeat (2) step();

        // starvation: continuous CPU and DMA traffic
        s0 = cyc;
        grant_cyc.delete();
        repeat (32) begin
            gen(100, 100, 100);
            step();
        end
        chk("starve_grant_count", 80'(grant_cyc.size()), 80'd3);
        for (int k = 0; k < 3; k++)
            if (grant_cyc.size() > k) chk("starve_grant_cycle", 80'(grant_cyc[k] - s0), 80'(9 + 10 * k));

        // randomized traffic with occasional resets
        for (int blk = 0; blk < 15; blk++) begin
            int cp, dp, rp;
            cp = int'($urandom_range(100));
            dp = int'($urandom_range(20, 100));
            rp = int'($urandom_range(10, 100));
            for (int i = 0; i < 200; i++) begin
                rst = ($urandom_range(149) != 0);
                gen(cp, dp, rp);
                step();
            end
        end

        rst = 1'b1;
        repeat (30) begin
            gen(0, 0, 100);
            step();
        end
        chk("dma_rsp_queue_drained", 80'(exp_dma.size()), 80'd0);
        chk("cpu_read_queue_drained", 80'(exp_cpu.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
